// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver.
//   - Segment patterns for a common-anode display, bit order g..a, active-low.
//   - pow10(): constant power of ten, used to size the overflow limit.
//   - seg_decode(): BCD nibble to segment pattern (non-decimal nibbles blank).
//   - conv_state_t: states of the sequential binary-to-BCD converter.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int k = 0; k < n; k++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_start    : start strobe, honoured only while idle
//   i_value    : binary value, captured on an accepted start
//   o_busy     : high whenever the FSM is not idle
//   o_done     : one-cycle strobe (COMMIT state); o_bcd/o_ovf valid while high
//   o_bcd      : packed BCD result, nibble 0 = least significant digit
//   o_ovf      : value did not fit in DIGITS decimal digits
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_value,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_ovf
);

    localparam int          BCD_W = 4 * DIGITS;
    localparam int          CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [31:0] LIMIT = 32'(pow10(DIGITS));

    conv_state_t        r_state;
    conv_state_t        w_state_next;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               w_over;
    logic               w_last;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_bcd_next;
    logic [BIN_W-1:0]   w_bin_next;

    assign w_over = (32'(i_value) >= LIMIT);
    assign w_last = (r_cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = w_over ? COMMIT : CONV;
            CONV:    if (w_last)  w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every nibble >= 5, then shift left.
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_adj[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = w_adj[4*k +: 4] + 4'd3;
            end
        end
        w_bcd_next = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
        w_bin_next = {r_bin[BIN_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_bcd <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_bin <= i_value;
                        r_bcd <= '0;
                        r_cnt <= '0;
                        r_ovf <= w_over;
                    end
                end
                CONV: begin
                    r_bin <= w_bin_next;
                    r_bcd <= w_bcd_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == COMMIT);
    assign o_bcd  = r_bcd;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed seven-segment driver with sequential binary-to-BCD conversion,
// leading-zero blanking, per-digit decimal points, blink and overflow dashes.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   value     : binary number, captured on an accepted load
//   load      : conversion start strobe (ignored while busy)
//   blank_lz  : blank leading zeros (live)
//   dp        : per-digit decimal point, 1 = lit, bit 0 = rightmost (live)
//   blink     : per-digit blink enable (live)
//   busy      : conversion in progress
//   display   : segments g..a, active-low, registered
//   dp_out    : decimal-point segment, active-low, registered
//   digit     : digit enables, active-low, one-hot-zero, registered
module bcd_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS            = 4,
    parameter int BIN_W             = 14,
    parameter int SCAN_DIV_W        = 17,
    parameter int BLINK_FRAMES_LOG2 = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  value,
    input  logic              load,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp,
    input  logic [DIGITS-1:0] blink,
    output logic              busy,
    output logic [6:0]        display,
    output logic              dp_out,
    output logic [DIGITS-1:0] digit
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRM_W = BLINK_FRAMES_LOG2 + 1;

    logic                   w_done;
    logic [4*DIGITS-1:0]    w_bcd;
    logic                   w_ovf;
    logic [4*DIGITS-1:0]    r_shown;
    logic                   r_shown_ovf;
    logic [SCAN_DIV_W-1:0]  r_presc;
    logic [IDX_W-1:0]       r_idx;
    logic [FRM_W-1:0]       r_frame;
    logic                   w_step;
    logic                   w_idx_last;
    logic [IDX_W+1:0]       w_base;
    logic [3:0]             w_nib;
    logic                   w_lz;
    logic [6:0]             w_seg;
    logic                   w_dpn;
    logic [DIGITS-1:0]      w_dig;
    logic [6:0]             r_display;
    logic                   r_dp_out;
    logic [DIGITS-1:0]      r_digit;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .i_start (load),
        .i_value (value),
        .o_busy  (busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd),
        .o_ovf   (w_ovf)
    );

    // Shown register: only ever loaded from a finished conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shown     <= '0;
            r_shown_ovf <= 1'b0;
        end else if (w_done) begin
            r_shown     <= w_bcd;
            r_shown_ovf <= w_ovf;
        end
    end

    // Scanner: prescaler -> digit index -> frame counter.
    assign w_step     = &r_presc;
    assign w_idx_last = (r_idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_frame <= '0;
        end else begin
            r_presc <= r_presc + SCAN_DIV_W'(1);
            if (w_step) begin
                r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
                if (w_idx_last) r_frame <= r_frame + FRM_W'(1);
            end
        end
    end

    // A digit is a leading zero when it and every more significant nibble are
    // zero; digit 0 is excluded so that the value 0 still shows "0".
    assign w_base = {r_idx, 2'b00};
    assign w_nib  = r_shown[w_base +: 4];
    assign w_lz   = (r_idx != '0) && ((r_shown >> w_base) == '0);
    assign w_dig  = ~(DIGITS'(1) << r_idx);

    always_comb begin
        w_seg = seg_decode(w_nib);
        w_dpn = ~dp[r_idx];
        if (r_shown_ovf) begin
            w_seg = SEG_DASH;
            w_dpn = 1'b1;
        end else if (blink[r_idx] && r_frame[FRM_W-1]) begin
            w_seg = SEG_BLANK;
            w_dpn = 1'b1;
        end else if (blank_lz && w_lz) begin
            w_seg = SEG_BLANK;
        end
    end

    // Output register: segments and enable switch together, so only one
    // digit is ever driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_display <= SEG_BLANK;
            r_dp_out  <= 1'b1;
            r_digit   <= '1;
        end else begin
            r_display <= w_seg;
            r_dp_out  <= w_dpn;
            r_digit   <= w_dig;
        end
    end

    assign display = r_display;
    assign dp_out  = r_dp_out;
    assign digit   = r_digit;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display (DIGITS=4, BIN_W=14, SCAN_DIV_W=2,
// BLINK_FRAMES_LOG2=1). A digit slot lasts 4 clocks, a frame 16 clocks, and
// the blink phase is off in frames 2 and 3 of every 4.
module tb_bcd_scan_display;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19, S7 = 7'h78, S9 = 7'h10;
    localparam logic [6:0] SB = 7'h7F, SD = 7'h3F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [13:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blink = '0;
    logic        busy;
    logic [6:0]  display;
    logic        dp_out;
    logic [3:0]  digit;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int bc;

    bcd_scan_display #(
        .DIGITS            (4),
        .BIN_W             (14),
        .SCAN_DIV_W        (2),
        .BLINK_FRAMES_LOG2 (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .blank_lz (blank_lz),
        .dp       (dp),
        .blink    (blink),
        .busy     (busy),
        .display  (display),
        .dp_out   (dp_out),
        .digit    (digit)
    );

    always #5 clk = ~clk;

    // Clocks since the last reset release; equals the DUT prescaler count.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Watch 64 clocks (four frames). Output in clock N reflects the index and
    // frame of clock N-1: index = ((N-1)/4)%4, frame = ((N-1)/16)%4.
    task automatic check_scan(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] dpn, input logic [3:0] bmask);
        logic [6:0] segs [4];
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic [3:0] exp_dig;
        logic       off;
        int         m, i;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            m       = cyc - 1;
            i       = (m / 4) % 4;
            off     = ((m / 16) % 4) >= 2;
            exp_dig = ~(4'b0001 << i);
            exp_seg = (bmask[i] && off) ? SB : segs[i];
            exp_dp  = (bmask[i] && off) ? 1'b1 : dpn[i];
            chk({tag, "_digit"}, 32'(digit), 32'(exp_dig));
            chk({tag, "_seg"}, 32'(display), 32'(exp_seg));
            chk({tag, "_dp"}, 32'(dp_out), 32'(exp_dp));
        end
    endtask

    task automatic do_load(input logic [13:0] v, output int cnt);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        cnt   = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_display", 32'(display), 32'h7F);
        chk("rst_digit", 32'(digit), 32'hF);
        chk("rst_dp", 32'(dp_out), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        check_scan("zero", S0, S0, S0, S0, 4'hF, 4'h0);

        // Plain conversion
        do_load(14'd1234, bc);
        chk("busy_len_1234", 32'(bc), 32'd15);
        check_scan("v1234", S1, S2, S3, S4, 4'hF, 4'h0);

        // Leading-zero blanking, dp still honoured on a blanked digit
        blank_lz = 1'b1;
        dp       = 4'b0100;
        do_load(14'd7, bc);
        chk("busy_len_7", 32'(bc), 32'd15);
        check_scan("lz7", SB, SB, SB, S7, 4'b1011, 4'h0);
        dp = 4'b0000;
        do_load(14'd0, bc);
        check_scan("lz0", SB, SB, SB, S0, 4'hF, 4'h0);
        do_load(14'd1002, bc);
        check_scan("lz1002", S1, S0, S0, S2, 4'hF, 4'h0);

        // Overflow: dashes, dp forced off
        blank_lz = 1'b0;
        dp       = 4'hF;
        do_load(14'd12000, bc);
        chk("busy_len_ovf", 32'(bc), 32'd1);
        check_scan("ovf12000", SD, SD, SD, SD, 4'hF, 4'h0);
        dp = 4'h0;
        do_load(14'd9999, bc);
        chk("busy_len_9999", 32'(bc), 32'd15);
        check_scan("v9999", S9, S9, S9, S9, 4'hF, 4'h0);
        do_load(14'd10000, bc);
        chk("busy_len_10000", 32'(bc), 32'd1);
        check_scan("ovf10000", SD, SD, SD, SD, 4'hF, 4'h0);

        // A load during conversion is dropped
        @(negedge clk);
        value = 14'd9999;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        for (int k = 0; k < 15; k++) begin
            chk("drop_busy", 32'(busy), 32'h1);
            if (k == 3) begin
                value = 14'd55;
                load  = 1'b1;
            end
            if (k == 4) load = 1'b0;
            @(negedge clk);
        end
        chk("drop_idle", 32'(busy), 32'h0);
        check_scan("drop", S9, S9, S9, S9, 4'hF, 4'h0);

        // Reset in the middle of a conversion
        @(negedge clk);
        value = 14'd1234;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_display", 32'(display), 32'h7F);
        rst = 1'b0;
        check_scan("midrst", S0, S0, S0, S0, 4'hF, 4'h0);

        // Load coincident with reset is ignored
        rst   = 1'b1;
        value = 14'd77;
        load  = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        chk("rstload_busy0", 32'(busy), 32'h0);
        @(negedge clk);
        chk("rstload_busy1", 32'(busy), 32'h0);
        check_scan("rstload", S0, S0, S0, S0, 4'hF, 4'h0);

        // Blink on digit 0 only
        do_load(14'd1234, bc);
        blink = 4'b0001;
        check_scan("blink", S1, S2, S3, S4, 4'hF, 4'b0001);
        blink = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
